// File: rtl/count_test_engine.sv
// count_test_engine: directed stimulus sequencer and self-checker for a loadable decade counter.
//
// Runs IDLE -> RST -> LOAD -> COUNT(RUN_CYCLES) -> HOLD(2) -> PRI -> DONE -> IDLE on a start request.
// It drives the counter's reset, Load, Enable and P. It also tracks the expected counter value and
// compares it against Q_in.
//
// Ports:
//   CLK        clock, all logic on posedge
//   MR         synchronous active-high reset, aborts any sequence
//   start      one-cycle run request, honoured only in IDLE
//   Q_in       counter output under check
//   cnt_rst    counter master reset (RST state)
//   Load       counter parallel-load strobe (LOAD, PRI)
//   Enable     counter count enable (COUNT, PRI)
//   P          counter parallel-load data
//   busy       high in every state except IDLE
//   done       one-cycle pulse in DONE
//   pass       set on leaving DONE when no mismatch was seen, held until next start or MR
//   err_count  saturating mismatch count
//
// Optional build macro FIRST_ERR_CAPTURE_EN adds first_err_exp, first_err_act and first_err_vld.
// These outputs latch the expected and observed values of the first mismatch after start.
module count_test_engine #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 10,
    parameter int RUN_CYCLES = 20,
    parameter int LOAD_VALUE = 7,
    parameter int PRI_VALUE  = 3
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             start,
    input  logic [WIDTH-1:0] Q_in,
    output logic             cnt_rst,
    output logic             Load,
    output logic             Enable,
    output logic [WIDTH-1:0] P,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act,
    output logic             first_err_vld
`endif
);
    typedef enum logic [2:0] {IDLE, RST, LOAD, COUNT, HOLD, PRI, DONE} state_t;
    state_t           state, state_nx;
    logic [7:0]       cyc, cyc_nx;
    logic [WIDTH-1:0] exp_val, exp_nx;
    logic             chk, mism, accept;
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc + 8'd1;
        case (state)
            IDLE:    state_nx = start ? RST : IDLE;
            RST:     state_nx = LOAD;
            LOAD:    begin state_nx = COUNT; cyc_nx = '0; end
            COUNT:   if (cyc == 8'(RUN_CYCLES - 1)) begin state_nx = HOLD; cyc_nx = '0; end
            HOLD:    state_nx = (cyc == 8'd1) ? PRI : HOLD;
            PRI:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Mirror the counter: it samples the same registered stimulus on the same edge.
    // Load wins over Enable.
    always_comb begin
        exp_nx = cnt_rst ? '0
               : Load    ? P
               : Enable  ? ((exp_val == WIDTH'(MODULUS - 1)) ? '0 : exp_val + WIDTH'(1))
               : exp_val;
        chk    = state inside {LOAD, COUNT, HOLD, PRI, DONE};
        mism   = chk && (Q_in != exp_val);
        accept = (state == IDLE) && start;
    end
    always_ff @(posedge CLK) begin
        if (MR) begin
            state     <= IDLE;
            cyc       <= '0;
            cnt_rst   <= 1'b0;
            Load      <= 1'b0;
            Enable    <= 1'b0;
            P         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            exp_val   <= '0;
        end else begin
            state   <= state_nx;
            cyc     <= cyc_nx;
            // Stimulus is decoded from the next state so it is registered and valid throughout the state.
            cnt_rst <= state_nx == RST;
            Load    <= state_nx == LOAD || state_nx == PRI;
            Enable  <= state_nx == COUNT || state_nx == PRI;
            P       <= state_nx == LOAD ? WIDTH'(LOAD_VALUE) : state_nx == PRI ? WIDTH'(PRI_VALUE) : '0;
            busy    <= state_nx != IDLE;
            done    <= state_nx == DONE;
            exp_val <= exp_nx;
            if (accept) begin
                err_count <= '0;
                pass      <= 1'b0;
            end else begin
                if (mism && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                // The verdict includes the compare made on this last DONE edge.
                if (state == DONE)
                    pass <= (err_count == 8'd0) && !mism;
            end
        end
    end
`ifdef FIRST_ERR_CAPTURE_EN
    always_ff @(posedge CLK) begin
        if (MR || accept) begin
            first_err_exp <= '0;
            first_err_act <= '0;
            first_err_vld <= 1'b0;
        end else if (mism && !first_err_vld) begin
            first_err_exp <= exp_val;
            first_err_act <= Q_in;
            first_err_vld <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_count_test_engine.sv
// tb_count_test_engine: randomized self-checking bench for count_test_engine with a behavioural counter.
module tb_count_test_engine;
    logic       clk = 1'b0;
    logic       MR = 1'b1;
    logic       start = 1'b0;
    logic [3:0] Q_in;
    logic [3:0] q = 4'd0;
    logic [3:0] noise = 4'd0;
    logic       cnt_rst, Load, Enable, busy, done, pass;
    logic [3:0] P;
    logic [7:0] err_count;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [3:0] first_err_exp, first_err_act;
    logic       first_err_vld;
`endif
    int fault = 0;
    int n_chk = 0;
    int n_pass = 0;
    int e[25];
    bit last_pass = 1'b0;

    count_test_engine dut (
        .CLK(clk), .MR(MR), .start(start), .Q_in(Q_in),
        .cnt_rst(cnt_rst), .Load(Load), .Enable(Enable), .P(P),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_exp(first_err_exp), .first_err_act(first_err_act), .first_err_vld(first_err_vld)
`endif
    );

    always #5 clk = ~clk;
    assign Q_in = q ^ noise;

    function automatic logic [3:0] inc(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    // Decade counter under test.
    // fault 1 ignores Enable.
    // fault 2 lets Enable beat Load when both are high.
    always @(posedge clk)
        q <= cnt_rst ? 4'd0
           : (fault == 2 && Load && Enable) ? inc(q)
           : Load ? P
           : (Enable && fault != 1) ? inc(q)
           : q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, req);
    endtask

    // Expected stimulus {cnt_rst, Load, Enable, P, busy, done} k cycles after the start edge.
    function automatic logic [8:0] stim(input int k);
        return {k == 1, k == 2 || k == 25, (k >= 3 && k <= 22) || k == 25,
                k == 2 ? 4'd7 : k == 25 ? 4'd3 : 4'd0, k >= 1 && k <= 26, k == 26};
    endfunction

    task automatic run(input int f, input int noise_pct, input int hold, input int busy_start_pct);
        int mism = 0;
        bit fe_vld = 1'b0;
        logic [3:0] fe_exp = 4'd0;
        logic [3:0] fe_act = 4'd0;
        repeat (2) @(negedge clk);
        check("pass_hold", pass, last_pass);
        fault = f;
        start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            start = (k < hold) || (k >= 2 && k <= 26 && $urandom_range(99) < busy_start_pct);
            check("stim", {cnt_rst, Load, Enable, P, busy, done}, stim(k));
            check("err_count", err_count, mism);
            check("pass", pass, k == 27 ? (mism == 0) : 0);
            if (k >= 2 && k <= 26) begin
                noise = ($urandom_range(99) < noise_pct) ? 4'($urandom_range(15, 1)) : 4'd0;
                if ((q ^ noise) != 4'(e[k-2])) begin
                    mism++;
                    if (!fe_vld) begin
                        fe_vld = 1'b1;
                        fe_exp = 4'(e[k-2]);
                        fe_act = q ^ noise;
                    end
                end
            end else noise = 4'd0;
        end
        last_pass = (mism == 0);
`ifdef FIRST_ERR_CAPTURE_EN
        check("first_vld", first_err_vld, fe_vld);
        check("first_exp", first_err_exp, fe_exp);
        check("first_act", first_err_act, fe_act);
`endif
    endtask

    initial begin
        int dones;
        e[0] = 0;
        for (int i = 0; i < 20; i++) e[1+i] = (7 + i) % 10;
        for (int i = 21; i < 24; i++) e[i] = (7 + 20) % 10;
        e[24] = 3;
        repeat (2) @(negedge clk);
        check("rst_stim", {cnt_rst, Load, Enable, P, busy, done}, 0);
        check("rst_err", err_count, 0);
        check("rst_pass", pass, 0);
        MR = 1'b0;
        run(0, 0, 1, 0);
        run(1, 0, 1, 0);
        run(2, 0, 1, 0);
        run(0, 0, 3, 0);
        run(0, 0, 1, 30);
        for (int r = 0; r < 6; r++)
            run($urandom_range(2), $urandom_range(1) ? 15 : 0, $urandom_range(3, 1), 20);
        fault = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        MR = 1'b1;
        @(negedge clk);
        MR = 1'b0;
        check("abort_stim", {cnt_rst, Load, Enable, P, busy, done}, 0);
        check("abort_err", err_count, 0);
        check("abort_pass", pass, 0);
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            dones += int'(done) + int'(busy);
        end
        check("abort_idle", dones, 0);
        last_pass = 1'b0;
        run(0, 0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
